// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the 4-digit scanned 7-segment display.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  // Index of the most significant nonzero nibble; 0 when the value is all zero.
  function automatic digit_idx_t msd_nibble(input logic [15:0] v);
    digit_idx_t m;
    m = '0;
    for (int i = 1; i < 4; i++) begin
      if (v[4*i +: 4] != 4'h0) m = digit_idx_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Latches ALU result/Zero via load/ack and scans it onto a 4-digit common-anode display,
// swapping in new data only at frame boundaries.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        zero_in,
  output logic        ack,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  digit_idx_t    digit_q, digit_d;
  logic [15:0]   shadow_q, shadow_d, active_q, active_d;
  logic          shadow_zero_q, shadow_zero_d, active_zero_q, active_zero_d;
  logic          pending_q, pending_d, ack_q, ack_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    nibble_seg;
  digit_idx_t    msd;

  assign wrap = (prescaler_q == PS_LAST);

  always_comb begin
    prescaler_d   = wrap ? '0 : prescaler_q + 1'b1;
    digit_d       = wrap ? digit_q + 1'b1 : digit_q;
    shadow_d      = shadow_q;
    shadow_zero_d = shadow_zero_q;
    active_d      = active_q;
    active_zero_d = active_zero_q;
    pending_d     = pending_q;
    ack_d         = load;
    if (wrap && (digit_q == 2'd3) && pending_q) begin
      active_d      = shadow_q;
      active_zero_d = shadow_zero_q;
      pending_d     = 1'b0;
    end
    // A load in the boundary cycle lands after the swap and waits for the next frame.
    if (load) begin
      shadow_d      = data_in;
      shadow_zero_d = zero_in;
      pending_d     = 1'b1;
    end
  end

  // Outputs are derived from next-state values so the registered drive lines up with the slot.
  assign nibble = active_d[{digit_d, 2'b00} +: 4];
  assign msd    = msd_nibble(active_d);

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (prescaler_d != '0) begin
      an_d[digit_d] = 1'b0;
      seg_d = ((LZ_BLANK != 0) && (digit_d > msd)) ? SEG_BLANK : nibble_seg;
      dp_d  = !((digit_d == 2'd0) && active_zero_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q   <= '0;
      digit_q       <= '0;
      shadow_q      <= '0;
      shadow_zero_q <= 1'b0;
      active_q      <= '0;
      active_zero_q <= 1'b0;
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= 4'b1111;
    end else begin
      prescaler_q   <= prescaler_d;
      digit_q       <= digit_d;
      shadow_q      <= shadow_d;
      shadow_zero_q <= shadow_zero_d;
      active_q      <= active_d;
      active_zero_q <= active_zero_d;
      pending_q     <= pending_d;
      ack_q         <= ack_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign ack = ack_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench: table vectors, hand sequences and random loads against a frame-level model.
module tb_seg7_scan_display;

  localparam int SD = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        zero_in = 1'b0;
  logic        ack0, ack1, dp0, dp1;
  logic [6:0]  seg0, seg1;
  logic [3:0]  an0, an1;

  always #5 clk = ~clk;

  seg7_scan_display #(.SCAN_DIV(SD), .LZ_BLANK(1)) u_dut0 (
    .clk(clk), .reset(rst_n), .load(load), .data_in(data_in), .zero_in(zero_in),
    .ack(ack0), .seg(seg0), .dp(dp0), .an(an0)
  );

  seg7_scan_display #(.SCAN_DIV(SD), .LZ_BLANK(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .load(load), .data_in(data_in), .zero_in(zero_in),
    .ack(ack1), .seg(seg1), .dp(dp1), .an(an1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Frame-level model: e counts clock edges since reset; slot and digit follow by division.
  int          e = 0;
  logic [15:0] disp = '0, pv = '0;
  logic        dispz = 1'b0, pz = 1'b0, pend = 1'b0, ack_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0; disp <= '0; dispz <= 1'b0; pv <= '0; pz <= 1'b0; pend <= 1'b0; ack_m <= 1'b0;
    end else begin
      e     <= e + 1;
      ack_m <= load;
      if (((e + 1) % FRAME == 0) && pend) begin
        disp  <= pv;
        dispz <= pz;
      end
      pend <= load | (pend & ((e + 1) % FRAME != 0));
      if (load) begin
        pv <= data_in;
        pz <= zero_in;
      end
    end
  end

  task automatic exp_out(input bit lz, output logic [3:0] ea, output logic [6:0] es, output logic ed);
    int ps, dg;
    ps = e % SD;
    dg = (e / SD) % 4;
    ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
    if (ps != 0) begin
      ea = ~(4'b0001 << dg);
      if (lz && dg > 0 && (disp >> (4 * dg)) == 16'h0) es = 7'b1111111;
      else es = hex7(disp[4*dg +: 4]);
      ed = !(dg == 0 && dispz);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    exp_out(1'b1, ea, es, ed);
    chk("an_lz1", an0, ea);  chk("seg_lz1", seg0, es);  chk("dp_lz1", dp0, ed);
    chk("ack_lz1", ack0, ack_m);
    exp_out(1'b0, ea, es, ed);
    chk("an_lz0", an1, ea);  chk("seg_lz0", seg1, es);  chk("dp_lz0", dp1, ed);
    chk("ack_lz0", ack1, ack_m);
  end

  task automatic wait_phase(input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (e % FRAME == p) found = 1'b1;
    end
    chk("wait_phase_timeout", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_slot(input int dg);
    wait_phase(dg * SD + 2);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic z);
    load = 1'b1; data_in = d; zero_in = z;
    @(negedge clk);
    load = 1'b0;
  endtask

  typedef struct {
    bit          do_load;
    logic [15:0] data;
    bit          z;
    bit          lz;
    int          dg;
    logic [6:0]  seg;
    bit          dp;
  } vec_t;

  vec_t vec[13];

  initial begin
    int acks;
    vec = '{
      '{1'b1, 16'h12AF, 1'b0, 1'b1, 0, 7'b0001110, 1'b1},
      '{1'b0, 16'h12AF, 1'b0, 1'b1, 1, 7'b0001000, 1'b1},
      '{1'b0, 16'h12AF, 1'b0, 1'b1, 2, 7'b0100100, 1'b1},
      '{1'b0, 16'h12AF, 1'b0, 1'b1, 3, 7'b1111001, 1'b1},
      '{1'b1, 16'h0030, 1'b0, 1'b1, 3, 7'b1111111, 1'b1},
      '{1'b0, 16'h0030, 1'b0, 1'b1, 2, 7'b1111111, 1'b1},
      '{1'b0, 16'h0030, 1'b0, 1'b1, 1, 7'b0110000, 1'b1},
      '{1'b0, 16'h0030, 1'b0, 1'b1, 0, 7'b1000000, 1'b1},
      '{1'b0, 16'h0030, 1'b0, 1'b0, 3, 7'b1000000, 1'b1},
      '{1'b0, 16'h0030, 1'b0, 1'b0, 2, 7'b1000000, 1'b1},
      '{1'b1, 16'h0000, 1'b1, 1'b1, 0, 7'b1000000, 1'b0},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1, 7'b1111111, 1'b1},
      '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 7'b1000000, 1'b1}
    };

    // Reset and first frame
    repeat (3) @(negedge clk);
    chk("rst_an", an0, 4'b1111);  chk("rst_seg", seg0, 7'b1111111);
    chk("rst_dp", dp0, 1'b1);     chk("rst_ack", ack0, 1'b0);
    rst_n = 1'b1;
    wait_slot(0); chk("init_d0_seg", seg0, 7'b1000000); chk("init_d0_an", an0, 4'b1110);
    wait_slot(1); chk("init_d1_seg", seg0, 7'b1111111); chk("init_d1_an", an0, 4'b1101);
    wait_slot(3); chk("init_d3_seg", seg0, 7'b1111111);

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      if (vec[i].do_load) begin
        pulse_load(vec[i].data, vec[i].z);
        chk("vec_ack", ack0, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
      end
      wait_slot(vec[i].dg);
      chk($sformatf("vec%0d_seg", i), vec[i].lz ? seg0 : seg1, vec[i].seg);
      chk($sformatf("vec%0d_dp", i), vec[i].lz ? dp0 : dp1, vec[i].dp);
    end

    // Back-to-back loads within one frame: last wins, both acked
    wait_phase(1);
    acks = 0;
    pulse_load(16'h1111, 1'b0); acks += int'(ack0);
    @(negedge clk);
    pulse_load(16'h2222, 1'b0); acks += int'(ack0);
    chk("b2b_acks", acks, 2);
    wait_slot(0); chk("b2b_d0", seg0, 7'b0100100);
    wait_slot(3); chk("b2b_d3", seg0, 7'b0100100);

    // Load in the boundary cycle waits one more frame
    wait_phase(FRAME - 1);
    pulse_load(16'h3333, 1'b0);
    wait_slot(0); chk("bnd_old", seg0, 7'b0100100);
    wait_slot(0); chk("bnd_new", seg0, 7'b0110000);

    // Reset mid-frame with a load pending
    wait_phase(3);
    pulse_load(16'h4444, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an0, 4'b1111);  chk("mid_rst_seg", seg0, 7'b1111111);
    chk("mid_rst_dp", dp0, 1'b1);     chk("mid_rst_ack", ack0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      acks += int'(ack0);
      if (e % FRAME == 2) begin
        chk("post_rst_d0", seg0, 7'b1000000);
        chk("post_rst_dp", dp0, 1'b1);
      end
    end
    chk("post_rst_acks", acks, 0);

    // Random loads at random times; the negedge checker compares every cycle
    for (int n = 0; n < 200; n++) begin
      logic [15:0] d;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: d = d & 16'h00FF;
        1: d = d & 16'h000F;
        default: ;
      endcase
      pulse_load(d, 1'($urandom_range(0, 1)));
    end
    repeat (3 * FRAME) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
